uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud-select encoding and helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    typedef enum logic {
        BAUD_9600 = 1'b0,
        BAUD_4800 = 1'b1
    } baud_sel_e;

    function automatic int unsigned bit_period(input int unsigned clks_per_bit,
                                               input baud_sel_e   sel);
        return (sel == BAUD_4800) ? 2 * clks_per_bit : clks_per_bit;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit cycle counter: pulses bit_tick on the last cycle of every bit period.
// Restarts from zero whenever a new frame is accepted.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      en,
    input  baud_sel_e baud_sel,
    output logic      bit_tick
);

    localparam int CW = $clog2(2 * CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d, last;

    always_comb begin
        last     = CW'(bit_period(CLKS_PER_BIT, baud_sel) - 1);
        bit_tick = en && (cnt_q == last);
        cnt_d    = cnt_q + 1'b1;
        if (start || !en || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All frame settings are captured when the byte is accepted.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       baud_sel,
    input  logic       par_en,
    input  logic       par_odd,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  next_idx;
    baud_sel_e   baud_q, baud_d;
    logic        par_en_q, par_en_d;
    logic        par_odd_q, par_odd_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        bit_tick;

    assign accept   = (state_q == IDLE) && tx_valid;
    assign next_idx = bit_idx_q + 3'd1;
    assign tx_ready = (state_q == IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .en      (busy_q),
        .baud_sel(baud_q),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = START;
                    data_d     = tx_data;
                    baud_d     = baud_sel_e'(baud_sel);
                    par_en_d   = par_en;
                    par_odd_d  = par_odd;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = data_q[0];
                end
            end
            // The index stops at 7 and hands over to parity or stop rather than wrapping.
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = parity_bit(data_q, par_odd_q);
                        end else begin
                            state_d    = STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = data_q[next_idx];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            bit_idx_q  <= '0;
            baud_q     <= BAUD_9600;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a per-cycle frame model checked every cycle,
// plus directed frames with hand-computed line patterns and timings.
module tb_uart_tx;

    localparam int CPB = 16;
    localparam int SB  = 1;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       baud_sel;
    logic       par_en;
    logic       par_odd;
    logic       tx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .baud_sel(baud_sel),
        .par_en  (par_en),
        .par_odd (par_odd),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {tx, busy, done, ready} for every cycle, derived from the frame layout.
    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic ready;
    } out_t;

    localparam out_t IDLE_OUT = 4'b1001;
    localparam out_t DONE_OUT = 4'b1011;

    out_t exp_q[$];
    out_t cur;
    bit   chk_en = 1'b0;

    function automatic void buildFrame(input logic [7:0] d, input logic b,
                                       input logic pe, input logic po);
        logic lbits[$];
        int   n;
        n = b ? 2 * CPB : CPB;
        lbits.push_back(1'b0);
        for (int i = 0; i < 8; i++) lbits.push_back(d[i]);
        if (pe) lbits.push_back(logic'(($countones(d) % 2) == 1) ^ po);
        for (int i = 0; i < SB; i++) lbits.push_back(1'b1);
        foreach (lbits[k]) begin
            for (int j = 0; j < n; j++) exp_q.push_back({lbits[k], 1'b1, 1'b0, 1'b0});
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur = IDLE_OUT;
        end else if (cur.ready && tx_valid) begin
            buildFrame(tx_data, baud_sel, par_en, par_odd);
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else if (cur.busy) begin
            cur = DONE_OUT;
        end else begin
            cur = IDLE_OUT;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({tx, busy, done, tx_ready} !== cur) begin
                bad++;
                $display("[TB] FAIL cycle_model t=%0t tx/busy/done/ready actual=%b required=%b",
                         $time, {tx, busy, done, tx_ready}, cur);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic b, input logic pe,
                                 input logic po, input logic v);
        tx_data  = d;
        baud_sel = b;
        par_en   = pe;
        par_odd  = po;
        tx_valid = v;
    endtask

    // Called at the negedge of the first start-bit cycle; samples each bit mid-period.
    task automatic sampleFrame(input int n, output logic [11:0] bits,
                               output int done_at, output int first_rise);
        bits       = '1;
        done_at    = -1;
        first_rise = -1;
        for (int c = 0; c < 1000; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % n) == n / 2 && (c / n) < 12) bits[c / n] = tx;
            if (first_rise < 0 && c > 0 && tx === 1'b1) first_rise = c;
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
        end
    endtask

    // Independent serial receiver working purely from the line.
    task automatic rxByte(input int n, input logic pe, input logic po,
                          output logic [7:0] rx, output logic perr, output logic stop_ok);
        int   waited;
        logic pbit;
        rx      = '0;
        perr    = 1'b1;
        stop_ok = 1'b0;
        pbit    = 1'b0;
        waited  = 0;
        while (tx !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) return;
        repeat (n / 2) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (n) @(negedge clk);
            rx[i] = tx;
        end
        if (pe) begin
            repeat (n) @(negedge clk);
            pbit = tx;
        end
        repeat (n) @(negedge clk);
        stop_ok = (tx === 1'b1);
        perr    = pe ? logic'((($countones(rx) + int'(pbit)) % 2) != int'(po)) : 1'b0;
    endtask

    task automatic waitIdle();
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        checkOutput("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0] bits;
        int          done_at;
        int          first_rise;
        logic [7:0]  rx;
        logic        perr;
        logic        stop_ok;
        logic        seen;

        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(tx_ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] frame 0xA5, no parity, 9600");
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        sampleFrame(CPB, bits, done_at, first_rise);
        checkOutput("a5_bits", 32'(bits[9:0]), 32'h34A);
        checkOutput("a5_done_at", 32'(done_at), 32'd160);
        checkOutput("a5_first_rise", 32'(first_rise), 32'd16);
        @(negedge clk);

        $display("[TB] frame 0x07, even then odd parity");
        applyStimulus(8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        sampleFrame(CPB, bits, done_at, first_rise);
        checkOutput("par_even_bit", 32'(bits[9]), 32'd1);
        checkOutput("par_even_data", 32'(bits[8:1]), 32'h07);
        checkOutput("par_even_len", 32'(done_at), 32'd176);
        @(negedge clk);
        applyStimulus(8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        sampleFrame(CPB, bits, done_at, first_rise);
        checkOutput("par_odd_bit", 32'(bits[9]), 32'd0);
        checkOutput("par_odd_stop", 32'(bits[10]), 32'd1);
        checkOutput("par_odd_len", 32'(done_at), 32'd176);
        @(negedge clk);

        $display("[TB] frame 0xFF at 4800 with settings changed mid-frame");
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        fork
            sampleFrame(2 * CPB, bits, done_at, first_rise);
            begin
                repeat (50) @(negedge clk);
                baud_sel = 1'b0;
                par_en   = 1'b1;
                tx_data  = 8'h00;
            end
        join
        checkOutput("ff_first_rise", 32'(first_rise), 32'd32);
        checkOutput("ff_done_at", 32'(done_at), 32'd320);
        checkOutput("ff_bits", 32'(bits[9:0]), 32'h3FE);
        @(negedge clk);

        $display("[TB] back-to-back 0x11 then 0x22");
        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h22;
        sampleFrame(CPB, bits, done_at, first_rise);
        checkOutput("b2b_first_bits", 32'(bits[9:1]), 32'h111);
        checkOutput("b2b_first_done", 32'(done_at), 32'd160);
        @(negedge clk);
        checkOutput("b2b_second_start_tx", 32'(tx), 32'd0);
        checkOutput("b2b_second_start_busy", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        fork
            sampleFrame(CPB, bits, done_at, first_rise);
            begin
                repeat (40) @(negedge clk);
                tx_data  = 8'h99;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        checkOutput("b2b_second_bits", 32'(bits[9:0]), 32'h244);
        checkOutput("b2b_second_done", 32'(done_at), 32'd160);
        repeat (5) @(negedge clk);
        checkOutput("busy_pulse_ignored", 32'(busy), 32'd0);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_tx", 32'(tx), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(tx_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 32'(seen), 32'd0);

        $display("[TB] loopback 0x3C at 4800, odd parity");
        fork
            begin
                applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
                @(posedge clk);
                @(negedge clk);
                tx_valid = 1'b0;
            end
            rxByte(2 * CPB, 1'b1, 1'b1, rx, perr, stop_ok);
        join
        checkOutput("loop_byte", 32'(rx), 32'h3C);
        checkOutput("loop_parity_err", 32'(perr), 32'd0);
        checkOutput("loop_stop", 32'(stop_ok), 32'd1);
        waitIdle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
